// File: rtl/ysyx_25040105_alu_arb.sv
// Two-port round-robin arbiter in front of the shared EXU ALU.
// A one-entry response buffer returns each result to the port that issued it.
module ysyx_25040105_alu_arb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_rs2,
    input  logic [XLEN-1:0]  req0_imm,
    input  logic [3:0]       req0_alu_op,
    input  logic             req0_alu_src,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_rs2,
    input  logic [XLEN-1:0]  req1_imm,
    input  logic [3:0]       req1_alu_op,
    input  logic             req1_alu_src,
    output logic [XLEN-1:0]  alu_rs1_data,
    output logic [XLEN-1:0]  alu_rs2_data,
    output logic [XLEN-1:0]  alu_imm,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    input  logic [XLEN-1:0]  alu_result,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [XLEN-1:0]  rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [XLEN-1:0]  rsp1_data,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic            buf_valid;
    logic            buf_id;
    logic [XLEN-1:0] buf_data;
    logic            last_gnt;
    logic            free;
    logic            gnt0;
    logic            gnt1;
    logic            consume;

    assign free = !buf_valid | (!buf_id & rsp0_ready) | (buf_id & rsp1_ready);

    // Grants are masked while reset is asserted so both ready outputs stay low.
    assign gnt0 = rst_n & free & req0_valid & (!req1_valid | last_gnt);
    assign gnt1 = rst_n & free & req1_valid & (!req0_valid | !last_gnt);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign rsp0_valid = buf_valid & !buf_id;
    assign rsp1_valid = buf_valid & buf_id;
    assign rsp0_data  = rsp0_valid ? buf_data : '0;
    assign rsp1_data  = rsp1_valid ? buf_data : '0;
    assign consume    = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    always_comb begin
        alu_rs1_data = '0;
        alu_rs2_data = '0;
        alu_imm      = '0;
        alu_op       = '0;
        alu_src      = 1'b0;
        if (gnt0) begin
            alu_rs1_data = req0_rs1;
            alu_rs2_data = req0_rs2;
            alu_imm      = req0_imm;
            alu_op       = req0_alu_op;
            alu_src      = req0_alu_src;
        end else if (gnt1) begin
            alu_rs1_data = req1_rs1;
            alu_rs2_data = req1_rs2;
            alu_imm      = req1_imm;
            alu_op       = req1_alu_op;
            alu_src      = req1_alu_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_id    <= 1'b0;
            buf_data  <= '0;
            last_gnt  <= 1'b1;
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                buf_data  <= alu_result;
                buf_id    <= gnt1;
                buf_valid <= 1'b1;
                last_gnt  <= gnt1;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
            if (gnt0 && gnt_cnt0 != '1)
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt1 && gnt_cnt1 != '1)
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_alu_arb.sv
// Directed bench for the ALU arbiter with a behavioural EXU model on the shared bus.
module tb_ysyx_25040105_alu_arb;

    typedef struct {
        int v0, v1, k0, rr0, rr1;
        int er0, er1, ev0, ed0, ev1, ed1, ealu, ec0, ec1;
    } vec_t;

    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req0_alu_src;
    logic [31:0] req0_rs1, req0_rs2, req0_imm;
    logic [3:0]  req0_alu_op;
    logic        req1_valid, req1_ready, req1_alu_src;
    logic [31:0] req1_rs1, req1_rs2, req1_imm;
    logic [3:0]  req1_alu_op;
    logic [31:0] alu_rs1_data, alu_rs2_data, alu_imm, alu_result;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    // Small-counter instance for the saturation test
    logic        s_valid, s_ready, s_r1ready, s_rsp0_valid, s_rsp1_valid, s_alu_src;
    logic [31:0] s_alu_rs1, s_alu_rs2, s_alu_imm, s_alu_result, s_rsp0_data, s_rsp1_data;
    logic [3:0]  s_alu_op;
    logic [1:0]  s_cnt0, s_cnt1;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic logic [31:0] exu(input logic [3:0] op, input logic src,
                                        input logic [31:0] a, input logic [31:0] rs2,
                                        input logic [31:0] imm);
        logic [31:0] b;
        b = src ? imm : rs2;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result   = exu(alu_op, alu_src, alu_rs1_data, alu_rs2_data, alu_imm);
    assign s_alu_result = exu(s_alu_op, s_alu_src, s_alu_rs1, s_alu_rs2, s_alu_imm);

    ysyx_25040105_alu_arb #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_alu_op(req0_alu_op),
        .req0_alu_src(req0_alu_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_alu_op(req1_alu_op),
        .req1_alu_src(req1_alu_src),
        .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data), .alu_imm(alu_imm),
        .alu_op(alu_op), .alu_src(alu_src), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    ysyx_25040105_alu_arb #(.XLEN(32), .CNT_W(2)) sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_valid), .req0_ready(s_ready), .req0_rs1(32'd1),
        .req0_rs2(32'd1), .req0_imm(32'd0), .req0_alu_op(4'd0), .req0_alu_src(1'b0),
        .req1_valid(1'b0), .req1_ready(s_r1ready), .req1_rs1(32'd0),
        .req1_rs2(32'd0), .req1_imm(32'd0), .req1_alu_op(4'd0), .req1_alu_src(1'b0),
        .alu_rs1_data(s_alu_rs1), .alu_rs2_data(s_alu_rs2), .alu_imm(s_alu_imm),
        .alu_op(s_alu_op), .alu_src(s_alu_src), .alu_result(s_alu_result),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(1'b1), .rsp0_data(s_rsp0_data),
        .rsp1_valid(s_rsp1_valid), .rsp1_ready(1'b1), .rsp1_data(s_rsp1_data),
        .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic add(input int v0, v1, k0, rr0, rr1, er0, er1, ev0, ed0,
                       ev1, ed1, ealu, ec0, ec1);
        vec_t v;
        v = '{v0, v1, k0, rr0, rr1, er0, er1, ev0, ed0, ev1, ed1, ealu, ec0, ec1};
        vecs.push_back(v);
    endtask

    // Port 0 kinds: 0 = SUB 10-3, 1 = ADD 5+7, 2 = unknown op 5 on 9
    task automatic set_p0(input int v, input int k);
        req0_valid   = (v != 0);
        req0_alu_src = 1'b0;
        req0_imm     = 32'd0;
        case (k)
            0: begin req0_rs1 = 32'd10; req0_rs2 = 32'd3; req0_alu_op = 4'd1; end
            1: begin req0_rs1 = 32'd5;  req0_rs2 = 32'd7; req0_alu_op = 4'd0; end
            default: begin req0_rs1 = 32'd9; req0_rs2 = 32'd1; req0_alu_op = 4'd5; end
        endcase
    endtask

    task automatic set_p1(input int v);
        req1_valid   = (v != 0);
        req1_rs1     = 32'd1;
        req1_rs2     = 32'd0;
        req1_imm     = 32'd4;
        req1_alu_op  = 4'd2;
        req1_alu_src = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_p0(0, 0);
        set_p1(0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        s_valid = 1'b0;

        //  v0 v1 k0 rr0 rr1 er0 er1 ev0 ed0 ev1 ed1 ealu ec0 ec1
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0,  0,  0, 0);
        add(1, 1, 0, 1, 1, 1, 0, 0, 0,  0, 0,  10, 0, 0);
        add(1, 1, 0, 1, 1, 0, 1, 1, 7,  0, 0,  1,  1, 0);
        add(1, 1, 0, 1, 1, 1, 0, 0, 0,  1, 16, 10, 1, 1);
        add(1, 1, 0, 1, 1, 0, 1, 1, 7,  0, 0,  1,  2, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 16, 0,  2, 2);
        add(1, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0,  5,  2, 2);
        add(0, 0, 0, 1, 1, 0, 0, 1, 12, 0, 0,  0,  3, 2);
        add(0, 1, 0, 1, 0, 0, 1, 0, 0,  0, 0,  1,  3, 2);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0,  1, 16, 0,  3, 3);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0,  1, 16, 0,  3, 3);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0,  1, 16, 0,  3, 3);
        add(1, 0, 1, 1, 1, 1, 0, 0, 0,  1, 16, 5,  3, 3);
        add(0, 0, 0, 1, 1, 0, 0, 1, 12, 0, 0,  0,  4, 3);
        add(1, 0, 2, 1, 1, 1, 0, 0, 0,  0, 0,  9,  4, 3);
        add(0, 0, 0, 1, 1, 0, 0, 1, 0,  0, 0,  0,  5, 3);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_p0(vecs[i].v0, vecs[i].k0);
            set_p1(vecs[i].v1);
            rsp0_ready = (vecs[i].rr0 != 0);
            rsp1_ready = (vecs[i].rr1 != 0);
            @(negedge clk);
            chk("req0_ready", i, 32'(req0_ready), vecs[i].er0);
            chk("req1_ready", i, 32'(req1_ready), vecs[i].er1);
            chk("rsp0_valid", i, 32'(rsp0_valid), vecs[i].ev0);
            chk("rsp0_data",  i, rsp0_data,       vecs[i].ed0);
            chk("rsp1_valid", i, 32'(rsp1_valid), vecs[i].ev1);
            chk("rsp1_data",  i, rsp1_data,       vecs[i].ed1);
            chk("alu_rs1",    i, alu_rs1_data,    vecs[i].ealu);
            chk("gnt_cnt0",   i, 32'(gnt_cnt0),   vecs[i].ec0);
            chk("gnt_cnt1",   i, 32'(gnt_cnt1),   vecs[i].ec1);
            @(posedge clk);
            #1;
        end

        // Reset mid-operation: held port 0 result, last grant was port 0
        set_p0(1, 1);
        set_p1(0);
        rsp0_ready = 1'b0;
        @(posedge clk);
        #1 set_p0(0, 1);
        #2;
        chk("hold_rsp0_valid", 100, 32'(rsp0_valid), 32'd1);
        chk("hold_rsp0_data",  100, rsp0_data, 32'd12);
        rst_n = 1'b0;
        #1;
        chk("async_rsp0_valid", 101, 32'(rsp0_valid), 32'd0);
        chk("async_rsp0_data",  101, rsp0_data, 32'd0);
        chk("async_gnt_cnt0",   101, 32'(gnt_cnt0), 32'd0);
        #1 rst_n = 1'b1;
        rsp0_ready = 1'b1;
        @(posedge clk);
        #1 set_p0(1, 0);
        set_p1(1);
        @(negedge clk);
        chk("post_rst_req0_ready", 102, 32'(req0_ready), 32'd1);
        chk("post_rst_req1_ready", 102, 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_rsp0_data",  103, rsp0_data, 32'd7);
        chk("post_rst_req1_ready", 103, 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1 set_p0(0, 0);
        set_p1(0);

        // Saturation on the 2-bit counter instance
        s_valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk("sat_ready", 200 + n, 32'(s_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("sat_cnt0", 200 + n, 32'(s_cnt0), (n < 3) ? n : 3);
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt0_hold", 210, 32'(s_cnt0), 32'd3);
        chk("sat_cnt1", 210, 32'(s_cnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040105_alu_arb.md
Name: ysyx_25040105_alu_arb

Overview:
Round-robin arbiter that shares the single combinational EXU ALU between two requesters: port 0 is the IDU issue path and port 1 is the LSU address-generation path. Each request is accepted through a valid/ready handshake and steered onto the shared ALU input bus. The ALU result is captured into a one-entry response buffer and returned to the owning requester through its own valid/ready handshake. Saturating per-port grant counters are provided for performance debug.

Parameters:
XLEN, 32, datapath width of operands and results
CNT_W, 16, width of each saturating grant counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_rs1  input  XLEN  port 0 operand 1
req0_rs2  input  XLEN  port 0 register operand 2
req0_imm  input  XLEN  port 0 immediate
req0_alu_op  input  4  port 0 ALU operation code (EXU encoding: 0 ADD, 1 SUB, 2 SLL, 3 SRL)
req0_alu_src  input  1  port 0 operand-2 select (0 = rs2, 1 = imm)
req1_valid, req1_ready, req1_rs1, req1_rs2, req1_imm, req1_alu_op, req1_alu_src  same directions and widths as port 0, for port 1
alu_rs1_data  output  XLEN  to shared EXU rs1_data
alu_rs2_data  output  XLEN  to shared EXU rs2_data
alu_imm  output  XLEN  to shared EXU imm
alu_op  output  4  to shared EXU alu_op
alu_src  output  1  to shared EXU alu_src
alu_result  input  XLEN  from shared EXU, combinational in the same cycle
rsp0_valid  output  1  port 0 result valid
rsp0_ready  input  1  port 0 result consumed
rsp0_data  output  XLEN  port 0 result
rsp1_valid, rsp1_ready, rsp1_data  same directions and widths as port 0, for port 1
gnt_cnt0  output  CNT_W  accepted-request count for port 0, saturating
gnt_cnt1  output  CNT_W  accepted-request count for port 1, saturating

Behaviour:
- State held by the block:
  - buf_valid: response buffer occupied
  - buf_id: owning port of the buffered result
  - buf_data: XLEN-bit buffered result
  - last_gnt: 1-bit round-robin pointer
  - two saturating grant counters
- Reset (rst_n low, takes effect immediately without waiting for clk):
  - buf_valid=0, buf_id=0, buf_data=0, last_gnt=1 (port 0 wins the first contention)
  - counters = 0
  - all rspX_valid=0, all reqX_ready=0
  - an in-flight result held in the buffer is discarded.
- Buffer status:
  - free = !buf_valid | (buf_id==0 & rsp0_ready) | (buf_id==1 & rsp1_ready)
  - This allows a back-to-back drain and refill in the same cycle.
- Grant (combinational, only when free=1):
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last_gnt is granted.
  - free=0: no grant.
- reqX_ready = grant to port X. reqX_ready never depends on reqX_ready of the other port or on rspX_data.
- ALU bus:
  - With a grant, the alu_* outputs carry the granted port's rs1/rs2/imm/alu_op/alu_src.
  - Without a grant, the alu_* outputs are all 0 (an ADD of 0+0).
- On a clock edge where a grant occurs:
  - buf_data <= alu_result, buf_id <= granted port, buf_valid <= 1
  - last_gnt <= granted port
  - the granted port's counter increments, saturating at all-ones.
- On a clock edge where the owner consumes (rsp ready & valid) and there is no new grant: buf_valid <= 0. buf_data and buf_id hold their values.
- Response outputs:
  - rspX_valid = buf_valid & (buf_id==X)
  - rspX_data = buf_data when rspX_valid, else 0
- Latency: a request accepted in cycle N has its response visible in cycle N+1.
- Throughput: 1 op per cycle when the owner's rsp_ready is held at 1.
- Backpressure: while the buffer holds an unconsumed result, both reqX_ready stay 0. The held result and buf_id stay stable until consumed.
- A port may not be granted twice in a row while the other port is continuously valid. This guarantees fairness (no starvation).
- Unknown alu_op values pass through unchanged; the EXU defines the result (0).

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles then released, no requests -> all ready/valid 0, gnt_cnt0=gnt_cnt1=0, alu_* outputs 0.
- Single port 0 ADD: req0 rs1=5, rs2=7, alu_src=0, op=0, rsp0_ready=1 -> req0_ready=1 in cycle N; rsp0_valid=1 with rsp0_data=12 in N+1; gnt_cnt0=1.
- Contention: both ports valid for 4 cycles (port 0 SUB 10-3, port 1 SLL 1<<imm=4), rsp ready=1 -> grants alternate 0,1,0,1; responses 7,16,7,16 on the correct rspX; each counter reaches 2.
- Backpressure: port 1 request accepted with rsp1_ready=0 for 3 cycles while port 0 is valid -> rsp1_data stable; req0_ready=0 for those 3 cycles; in the cycle rsp1_ready=1, req0 is granted (same-cycle drain and refill).
- Reset mid-operation: buffer holds a port 0 result and rst_n is pulsed low between clock edges -> rsp0_valid drops to 0 immediately; after release the next contention grants port 0 first.
- Counter saturation with CNT_W=2: 5 accepted port 0 requests -> gnt_cnt0 = 3 and stays at 3.
